// File: rtl/if_id_stage.sv
// IF stage plus IF/ID latch: PC select, instruction-memory addressing, flush bubbles.
// Latency: 1 edge from fetch to id_inst. Stall holds PC and latch; a redirect overrides stall.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ifid_t;

    logic [31:0]      r_pc;
    ifid_t            r_ifid;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [31:0]      w_pc4;
    logic [31:0]      w_jump_addr;
    logic             w_redirect;
    logic [31:0]      w_pc_next;
    ifid_t            w_ifid_next;
    logic             w_cnt_sat;

    assign w_pc4       = r_pc + 32'd4;
    // The j region nibble comes from the jump instruction's own PC+4 held in IF/ID.
    assign w_jump_addr = {r_ifid.pc4[31:28], jump_index, 2'b00};
    assign w_redirect  = branch_taken | jump;
    assign w_cnt_sat   = &r_bubble_cnt;

    always_comb begin
        w_pc_next = w_pc4;
        if (branch_taken) begin
            w_pc_next = branch_target;
        end else if (jump) begin
            w_pc_next = w_jump_addr;
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    // imem_data is only consumed on the plain-advance path, so junk during stall/redirect is ignored.
    always_comb begin
        w_ifid_next = r_ifid;
        if (w_redirect) begin
            w_ifid_next = '0;
        end else if (!stall) begin
            w_ifid_next.inst  = imem_data;
            w_ifid_next.pc4   = w_pc4;
            w_ifid_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ifid       <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_pc   <= w_pc_next;
            r_ifid <= w_ifid_next;
            if (w_redirect && !w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign imem_addr  = r_pc;
    assign id_inst    = r_ifid.inst;
    assign id_pc4     = r_ifid.pc4;
    assign id_valid   = r_ifid.valid;
    assign bubble_cnt = r_bubble_cnt;

endmodule
